rgb_to_ycbcr: RTL and testbench



---
 rtl/rgb_to_ycbcr.sv | 54 +++++
 tb/tb_rgb_to_ycbcr.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rgb_to_ycbcr.sv
// rgb_to_ycbcr: one-clock pipelined RGB to level-shifted signed YCbCr converter
//   clock, reset_n         : rising-edge clock, async active-low reset
//   in_valid, r, g, b      : 8-bit unsigned pixel, qualified by in_valid
//   out, out_valid         : {Y, Cb, Cr} signed 12-bit each, valid one clock later
module rgb_to_ycbcr #(
  parameter int IN_W = 8,
  parameter int OUT_W = 12,
  parameter int FRAC_W = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [IN_W-1:0]      r,
  input  logic [IN_W-1:0]      g,
  input  logic [IN_W-1:0]      b,
  output logic [3*OUT_W-1:0]   out,
  output logic                 out_valid
);
  localparam int ACC_W = IN_W + FRAC_W + 4;
  localparam logic signed [ACC_W-1:0] Y_R = ACC_W'(77);
  localparam logic signed [ACC_W-1:0] Y_G = ACC_W'(150);
  localparam logic signed [ACC_W-1:0] Y_B = ACC_W'(29);
  localparam logic signed [ACC_W-1:0] CB_R = -ACC_W'(43);
  localparam logic signed [ACC_W-1:0] CB_G = -ACC_W'(85);
  localparam logic signed [ACC_W-1:0] CB_B = ACC_W'(128);
  localparam logic signed [ACC_W-1:0] CR_R = ACC_W'(128);
  localparam logic signed [ACC_W-1:0] CR_G = -ACC_W'(107);
  localparam logic signed [ACC_W-1:0] CR_B = -ACC_W'(21);
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (FRAC_W - 1);
  localparam logic signed [ACC_W-1:0] Y_OFS = ACC_W'(128);
  logic signed [ACC_W-1:0] rs, gs, bs;
  logic signed [ACC_W-1:0] acc_y, acc_cb, acc_cr;
  logic signed [ACC_W-1:0] s_y, s_cb, s_cr;
  always_comb begin
    rs = ACC_W'(r);
    gs = ACC_W'(g);
    bs = ACC_W'(b);
    acc_y = Y_R * rs + Y_G * gs + Y_B * bs + RND;
    acc_cb = CB_R * rs + CB_G * gs + CB_B * bs + RND;
    acc_cr = CR_R * rs + CR_G * gs + CR_B * bs + RND;
    s_y = (acc_y >>> FRAC_W) - Y_OFS;
    s_cb = acc_cb >>> FRAC_W;
    s_cr = acc_cr >>> FRAC_W;
  end
  // results always lie within -128..128, so the low OUT_W bits are the sign-extended value
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      out <= '0;
      out_valid <= 1'b0;
    end else begin
      out <= {s_y[OUT_W-1:0], s_cb[OUT_W-1:0], s_cr[OUT_W-1:0]};
      out_valid <= in_valid;
    end
endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// tb_rgb_to_ycbcr: scoreboard bench for rgb_to_ycbcr
module tb_rgb_to_ycbcr;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic [35:0] out;
  logic out_valid;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic v;
    logic [35:0] d;
    string nm;
  } exp_t;
  exp_t sb[$];
  localparam logic [35:0] BLACK = 36'hF80000000;
  localparam logic [35:0] WHITE = 36'h07F000000;
  localparam logic [35:0] RED = 36'hFCDFD5080;
  localparam logic [35:0] GREEN = 36'h015FABF95;
  localparam logic [35:0] BLUE = 36'hF9D080FEB;
  rgb_to_ycbcr dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
    .r(r), .g(g), .b(b), .out(out), .out_valid(out_valid)
  );
  always #5 clock = ~clock;
  function automatic logic [11:0] chan(input int cr, input int cg, input int cb,
                                       input int rr, input int gg, input int bb, input int ofs);
    int acc, q;
    acc = cr * rr + cg * gg + cb * bb + 128;
    q = acc / 256;
    if (acc < 0 && (acc % 256) != 0) q = q - 1;
    return 12'(q - ofs);
  endfunction
  function automatic logic [35:0] model(input int rr, input int gg, input int bb);
    return {chan(77, 150, 29, rr, gg, bb, 128),
            chan(-43, -85, 128, rr, gg, bb, 0),
            chan(128, -107, -21, rr, gg, bb, 0)};
  endfunction
  task automatic drive(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                       input logic v, input logic [35:0] e, input string nm);
    @(negedge clock);
    r = rr; g = gg; b = bb; in_valid = v;
    sb.push_back('{v, e, nm});
  endtask
  task automatic check_next();
    exp_t e;
    @(posedge clock);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = sb.pop_front();
      if (out !== e.d) begin
        errors++;
        $display("FAIL %s out got %h want %h", e.nm, out, e.d);
      end
      checks++;
      if (out_valid !== e.v) begin
        errors++;
        $display("FAIL %s out_valid got %b want %b", e.nm, out_valid, e.v);
      end
    end
  endtask
  task automatic send(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                      input logic v, input logic [35:0] e, input string nm);
    drive(rr, gg, bb, v, e, nm);
    check_next();
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if (out !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial out=%h valid=%b want 0/0", out, out_valid);
    end
    @(negedge clock);
    r = 8'hFF; g = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (out !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held out=%h valid=%b want 0/0", out, out_valid);
    end
    @(negedge clock);
    reset_n = 1'b1;
    in_valid = 1'b0;
  endtask
  task automatic test_colours();
    send(8'd0, 8'd0, 8'd0, 1'b1, BLACK, "black");
    send(8'd255, 8'd255, 8'd255, 1'b1, WHITE, "white");
    send(8'd255, 8'd0, 8'd0, 1'b1, RED, "red");
    send(8'd0, 8'd255, 8'd0, 1'b1, GREEN, "green");
    send(8'd0, 8'd0, 8'd255, 1'b1, BLUE, "blue");
  endtask
  task automatic test_back_to_back();
    fork
      begin
        drive(8'd0, 8'd0, 8'd0, 1'b1, BLACK, "b2b_black");
        drive(8'd255, 8'd255, 8'd255, 1'b1, WHITE, "b2b_white");
        drive(8'd255, 8'd0, 8'd0, 1'b1, RED, "b2b_red");
        drive(8'd0, 8'd0, 8'd255, 1'b1, BLUE, "b2b_blue");
      end
      repeat (4) check_next();
    join
  endtask
  task automatic test_valid_pulse();
    send(8'd255, 8'd0, 8'd0, 1'b1, RED, "pulse_1");
    send(8'd0, 8'd255, 8'd0, 1'b0, GREEN, "pulse_0_ungated");
    send(8'd0, 8'd0, 8'd255, 1'b1, BLUE, "pulse_1b");
  endtask
  task automatic test_async_reset();
    send(8'd255, 8'd255, 8'd255, 1'b1, WHITE, "pre_reset");
    drive(8'd255, 8'd0, 8'd0, 1'b1, RED, "inflight");
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (out !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset out=%h valid=%b want 0/0", out, out_valid);
    end
    drive(8'd0, 8'd255, 8'd0, 1'b1, GREEN, "post_reset_green");
    reset_n = 1'b1;
    check_next();
  endtask
  task automatic test_random();
    logic [7:0] rr, gg, bb;
    logic v;
    for (int i = 0; i < 10000; i++) begin
      rr = 8'($urandom_range(0, 255));
      gg = 8'($urandom_range(0, 255));
      bb = 8'($urandom_range(0, 255));
      v = 1'($urandom_range(0, 1));
      send(rr, gg, bb, v, model(rr, gg, bb), "random");
    end
  endtask
  initial begin
    test_reset();
    test_colours();
    test_back_to_back();
    test_valid_pulse();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
